pulp_cluster_dma32_seq: RTL and testbench
=========================================

// Module: pulp_cluster_dma32_seq
// PURPOSE
//  Sequences the 32-bit ESP DMA interface of the pulp_cluster accelerator tile: on conf_done it copies
//  LEN words from DRAM word index RD_BASE to WR_BASE, chunk by chunk, through an internal CHUNK_WORDS
//  buffer. Sits between the ESP socket DMA ports and the cluster datapath; it replaces the tied-off
//  DMA stub. One acc_done pulse per configuration.
// PARAMETERS
//  CHUNK_WORDS  16  max words per DMA burst and buffer depth (power of 2, 2..256)
//  CNT_W        32  width of word counters and DMA index/length
// PORTS
//  clk                        in   1   clock, rising edge
//  rst                        in   1   asynchronous reset, active low
//  conf_info_reg1             in   32  RD_BASE: source word index
//  conf_info_reg2             in   32  WR_BASE: destination word index
//  conf_info_reg3             in   32  LEN: total words to move
//  conf_done                  in   1   configuration valid, starts a run
//  dma_read_ctrl_valid/ready  out/in 1 read request handshake
//  dma_read_ctrl_data_index   out  32  read word index
//  dma_read_ctrl_data_length  out  32  read burst length, words
//  dma_read_ctrl_data_size    out  3   fixed 3'b010 (32-bit word)
//  dma_read_ctrl_data_user    out  5   fixed 5'd0
//  dma_read_chnl_valid/ready  in/out 1 read data handshake
//  dma_read_chnl_data         in   32  read data word
//  dma_write_ctrl_valid/ready out/in 1 write request handshake
//  dma_write_ctrl_data_index/length/size/user  out 32/32/3/5  as read side
//  dma_write_chnl_valid/ready out/in 1 write data handshake
//  dma_write_chnl_data        out  32  write data word
//  acc_done                   out  1   one-cycle completion pulse
//  debug                      out  32  {chunks_done[15:0], 13'd0, state[2:0]}
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; all valids, ready, acc_done = 0; counters, buffer pointers = 0.
//  Handshake: transfer when valid&&ready on rising clk; valids held, payload stable until accepted.
//  States: IDLE(0) RD_REQ(1) RD_DATA(2) WR_REQ(3) WR_DATA(4) DONE(5) WAIT_CLR(6).
//  IDLE: conf_done=1 -> latch rd_idx=reg1, wr_idx=reg2, remain=reg3; remain==0 -> DONE, else RD_REQ.
//  chunk = min(remain, CHUNK_WORDS), computed on entry to RD_REQ, held through WR_DATA.
//  RD_REQ: read_ctrl_valid=1, index=rd_idx, length=chunk; on accept -> RD_DATA.
//  RD_DATA: read_chnl_ready=1; each beat writes buffer[wptr++]; after chunk beats -> WR_REQ.
//  WR_REQ: write_ctrl_valid=1, index=wr_idx, length=chunk; on accept -> WR_DATA.
//  WR_DATA: write_chnl_valid=1, data=buffer[rptr] (registered, no bubble between beats); after chunk
//   beats: rd_idx+=chunk, wr_idx+=chunk, remain-=chunk, chunks_done++, remain==0 ? DONE : RD_REQ.
//  DONE: acc_done=1 for exactly one cycle -> WAIT_CLR. WAIT_CLR: conf_done=0 -> IDLE (no re-run on
//   a held conf_done).
//  Buffer never overflows: read and write phases never overlap; pointers reset to 0 per chunk.
//  read_chnl_ready=0 outside RD_DATA; stray read beats there are ignored, not stored.
//  conf_info_* sampled only in IDLE; changes mid-run ignored. Index adds wrap modulo 2^CNT_W.
//  Last chunk may be short (LEN not multiple of CHUNK_WORDS). Async reset mid-run aborts to IDLE
//   with no acc_done; socket is reset together with the tile.
// TESTING
//  LEN=40,RD=0x100,WR=0x800,CHUNK=16 -> read reqs (0x100,16),(0x110,16),(0x120,8); writes at
//   0x800,0x810,0x820; data identical; one acc_done; debug[31:16]=3.
//  LEN=0, conf_done=1 -> no ctrl valids asserted; acc_done pulse 1 cycle later.
//  Random valid/ready stalls on all four channels, LEN=100 -> output stream equals input, no loss,
//   no duplicates; payload stable while valid&&!ready.
//  conf_done held high 50 cycles after done -> exactly one run; drop then raise -> second run.
//  Async rst during RD_DATA chunk 2 -> all outputs 0 immediately; next conf_done restarts from reg1.
//  LEN=16 exactly CHUNK -> single read and write burst of 16, acc_done once.

Source files
------------

// File: rtl/pulp_cluster_dma32_seq.sv
// rtl/pulp_cluster_dma32_seq.sv - chunked 32-bit DMA copy sequencer for the pulp_cluster tile
module pulp_cluster_dma32_seq #(
    parameter int CHUNK_WORDS = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      conf_info_reg1,
    input  logic [31:0]      conf_info_reg2,
    input  logic [31:0]      conf_info_reg3,
    input  logic             conf_done,
    output logic             dma_read_ctrl_valid,
    input  logic             dma_read_ctrl_ready,
    output logic [CNT_W-1:0] dma_read_ctrl_data_index,
    output logic [CNT_W-1:0] dma_read_ctrl_data_length,
    output logic [2:0]       dma_read_ctrl_data_size,
    output logic [4:0]       dma_read_ctrl_data_user,
    input  logic             dma_read_chnl_valid,
    output logic             dma_read_chnl_ready,
    input  logic [31:0]      dma_read_chnl_data,
    output logic             dma_write_ctrl_valid,
    input  logic             dma_write_ctrl_ready,
    output logic [CNT_W-1:0] dma_write_ctrl_data_index,
    output logic [CNT_W-1:0] dma_write_ctrl_data_length,
    output logic [2:0]       dma_write_ctrl_data_size,
    output logic [4:0]       dma_write_ctrl_data_user,
    output logic             dma_write_chnl_valid,
    input  logic             dma_write_chnl_ready,
    output logic [31:0]      dma_write_chnl_data,
    output logic             acc_done,
    output logic [31:0]      debug
);
    localparam int PTR_W = $clog2(CHUNK_WORDS);
    localparam int BW    = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_REQ   = 3'd1,
        S_RD_DATA  = 3'd2,
        S_WR_REQ   = 3'd3,
        S_WR_DATA  = 3'd4,
        S_DONE     = 3'd5,
        S_WAIT_CLR = 3'd6
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] rd_idx, wr_idx, remain, chunk, remain_nx;
    logic [BW-1:0]    beat, beat_inc;
    logic [15:0]      chunks_done;
    logic [31:0]      wdata_q;
    logic [31:0]      buffer [CHUNK_WORDS];
    logic             last_beat;

    function automatic logic [CNT_W-1:0] min_chunk(input logic [CNT_W-1:0] r);
        return (r > CNT_W'(CHUNK_WORDS)) ? CNT_W'(CHUNK_WORDS) : r;
    endfunction

    assign beat_inc  = beat + BW'(1);
    assign last_beat = (beat == chunk[BW-1:0] - BW'(1));
    assign remain_nx = remain - chunk;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx             = state;
        dma_read_ctrl_valid  = 1'b0;
        dma_read_chnl_ready  = 1'b0;
        dma_write_ctrl_valid = 1'b0;
        dma_write_chnl_valid = 1'b0;
        acc_done             = 1'b0;
        case (state)
            S_IDLE: begin
                if (conf_done)
                    state_nx = (conf_info_reg3 == 32'd0) ? S_DONE : S_RD_REQ;
            end
            S_RD_REQ: begin
                dma_read_ctrl_valid = 1'b1;
                if (dma_read_ctrl_ready) state_nx = S_RD_DATA;
            end
            S_RD_DATA: begin
                dma_read_chnl_ready = 1'b1;
                if (dma_read_chnl_valid && last_beat) state_nx = S_WR_REQ;
            end
            S_WR_REQ: begin
                dma_write_ctrl_valid = 1'b1;
                if (dma_write_ctrl_ready) state_nx = S_WR_DATA;
            end
            S_WR_DATA: begin
                dma_write_chnl_valid = 1'b1;
                if (dma_write_chnl_ready && last_beat)
                    state_nx = (remain == chunk) ? S_DONE : S_RD_REQ;
            end
            S_DONE: begin
                acc_done = 1'b1;
                state_nx = S_WAIT_CLR;
            end
            S_WAIT_CLR: begin
                if (!conf_done) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // chunk is reloaded whenever the next state will be RD_REQ, so it always reflects the pending burst
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_idx      <= '0;
            wr_idx      <= '0;
            remain      <= '0;
            chunk       <= '0;
            beat        <= '0;
            chunks_done <= '0;
            wdata_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (conf_done) begin
                        rd_idx      <= conf_info_reg1;
                        wr_idx      <= conf_info_reg2;
                        remain      <= conf_info_reg3;
                        chunk       <= min_chunk(conf_info_reg3);
                        chunks_done <= '0;
                        beat        <= '0;
                    end
                end
                S_RD_DATA: begin
                    if (dma_read_chnl_valid)
                        beat <= last_beat ? '0 : beat_inc;
                end
                S_WR_REQ: begin
                    if (dma_write_ctrl_ready) begin
                        wdata_q <= buffer[0];
                        beat    <= '0;
                    end
                end
                S_WR_DATA: begin
                    if (dma_write_chnl_ready) begin
                        // prefetch the next word so consecutive beats need no bubble
                        wdata_q <= buffer[beat_inc[PTR_W-1:0]];
                        if (last_beat) begin
                            beat        <= '0;
                            rd_idx      <= rd_idx + chunk;
                            wr_idx      <= wr_idx + chunk;
                            remain      <= remain_nx;
                            chunk       <= min_chunk(remain_nx);
                            chunks_done <= chunks_done + 16'd1;
                        end else begin
                            beat <= beat_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_RD_DATA && dma_read_chnl_valid)
            buffer[beat[PTR_W-1:0]] <= dma_read_chnl_data;
    end

    assign dma_read_ctrl_data_index   = rd_idx;
    assign dma_read_ctrl_data_length  = chunk;
    assign dma_read_ctrl_data_size    = 3'b010;
    assign dma_read_ctrl_data_user    = 5'd0;
    assign dma_write_ctrl_data_index  = wr_idx;
    assign dma_write_ctrl_data_length = chunk;
    assign dma_write_ctrl_data_size   = 3'b010;
    assign dma_write_ctrl_data_user   = 5'd0;
    assign dma_write_chnl_data        = wdata_q;
    assign debug                      = {chunks_done, 13'd0, state};

endmodule

// File: tb/tb_pulp_cluster_dma32_seq.sv
// tb/tb_pulp_cluster_dma32_seq.sv - self-checking bench for pulp_cluster_dma32_seq
module tb_pulp_cluster_dma32_seq;
    localparam int CW = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] conf_info_reg1, conf_info_reg2, conf_info_reg3;
    logic        conf_done;
    logic        dma_read_ctrl_valid, dma_read_ctrl_ready;
    logic [31:0] dma_read_ctrl_data_index, dma_read_ctrl_data_length;
    logic [2:0]  dma_read_ctrl_data_size;
    logic [4:0]  dma_read_ctrl_data_user;
    logic        dma_read_chnl_valid, dma_read_chnl_ready;
    logic [31:0] dma_read_chnl_data;
    logic        dma_write_ctrl_valid, dma_write_ctrl_ready;
    logic [31:0] dma_write_ctrl_data_index, dma_write_ctrl_data_length;
    logic [2:0]  dma_write_ctrl_data_size;
    logic [4:0]  dma_write_ctrl_data_user;
    logic        dma_write_chnl_valid, dma_write_chnl_ready;
    logic [31:0] dma_write_chnl_data;
    logic        acc_done;
    logic [31:0] debug;

    always #5 clk = ~clk;

    pulp_cluster_dma32_seq #(.CHUNK_WORDS(CW), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .conf_info_reg1(conf_info_reg1), .conf_info_reg2(conf_info_reg2),
        .conf_info_reg3(conf_info_reg3), .conf_done(conf_done),
        .dma_read_ctrl_valid(dma_read_ctrl_valid), .dma_read_ctrl_ready(dma_read_ctrl_ready),
        .dma_read_ctrl_data_index(dma_read_ctrl_data_index),
        .dma_read_ctrl_data_length(dma_read_ctrl_data_length),
        .dma_read_ctrl_data_size(dma_read_ctrl_data_size),
        .dma_read_ctrl_data_user(dma_read_ctrl_data_user),
        .dma_read_chnl_valid(dma_read_chnl_valid), .dma_read_chnl_ready(dma_read_chnl_ready),
        .dma_read_chnl_data(dma_read_chnl_data),
        .dma_write_ctrl_valid(dma_write_ctrl_valid), .dma_write_ctrl_ready(dma_write_ctrl_ready),
        .dma_write_ctrl_data_index(dma_write_ctrl_data_index),
        .dma_write_ctrl_data_length(dma_write_ctrl_data_length),
        .dma_write_ctrl_data_size(dma_write_ctrl_data_size),
        .dma_write_ctrl_data_user(dma_write_ctrl_data_user),
        .dma_write_chnl_valid(dma_write_chnl_valid), .dma_write_chnl_ready(dma_write_chnl_ready),
        .dma_write_chnl_data(dma_write_chnl_data),
        .acc_done(acc_done), .debug(debug)
    );

    int          n_checks = 0;
    int          n_errs   = 0;
    int          stall_pct;
    logic [31:0] seed;
    bit          stray_mode;
    bit          ctrl_seen;
    int          acc_cnt, acc_base;
    logic [31:0] rreq_idx[$], rreq_len[$], wreq_idx[$], wreq_len[$];
    logic [31:0] beat_q[$], wlog_addr[$], wlog_data[$];
    logic [31:0] wr_cur;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] src(input logic [31:0] idx);
        return (idx * 32'h9E37_79B1) ^ seed;
    endfunction

    function automatic bit stall();
        return int'($urandom_range(0, 99)) < stall_pct;
    endfunction

    // Socket model: random ready/valid on all four channels, logs every accepted transfer.
    initial begin : agents
        bit          rd_pend, prev_acc;
        bit          p_rc_v, p_rc_r, p_wc_v, p_wc_r, p_wd_v, p_wd_r;
        logic [31:0] p_rc_i, p_rc_l, p_wc_i, p_wc_l, p_wd_d;
        dma_read_ctrl_ready = 0; dma_read_chnl_valid = 0; dma_read_chnl_data = 0;
        dma_write_ctrl_ready = 0; dma_write_chnl_ready = 0;
        rd_pend = 0; prev_acc = 0; acc_cnt = 0;
        {p_rc_v, p_rc_r, p_wc_v, p_wc_r, p_wd_v, p_wd_r} = '0;
        p_rc_i = 0; p_rc_l = 0; p_wc_i = 0; p_wc_l = 0; p_wd_d = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                dma_read_ctrl_ready = 0; dma_read_chnl_valid = 0; dma_read_chnl_data = 0;
                dma_write_ctrl_ready = 0; dma_write_chnl_ready = 0;
                beat_q.delete(); rd_pend = 0; prev_acc = 0;
                {p_rc_v, p_rc_r, p_wc_v, p_wc_r, p_wd_v, p_wd_r} = '0;
                continue;
            end
            if (p_rc_v && !p_rc_r) begin
                check("rd_ctrl_valid_hold", {31'd0, dma_read_ctrl_valid}, 1);
                check("rd_ctrl_index_hold", dma_read_ctrl_data_index, p_rc_i);
                check("rd_ctrl_len_hold", dma_read_ctrl_data_length, p_rc_l);
            end
            if (p_wc_v && !p_wc_r) begin
                check("wr_ctrl_valid_hold", {31'd0, dma_write_ctrl_valid}, 1);
                check("wr_ctrl_index_hold", dma_write_ctrl_data_index, p_wc_i);
                check("wr_ctrl_len_hold", dma_write_ctrl_data_length, p_wc_l);
            end
            if (p_wd_v && !p_wd_r) begin
                check("wr_chnl_valid_hold", {31'd0, dma_write_chnl_valid}, 1);
                check("wr_chnl_data_hold", dma_write_chnl_data, p_wd_d);
            end
            if (dma_read_ctrl_valid || dma_write_ctrl_valid) ctrl_seen = 1;

            dma_read_ctrl_ready = !stall();
            if (dma_read_ctrl_valid && dma_read_ctrl_ready) begin
                rreq_idx.push_back(dma_read_ctrl_data_index);
                rreq_len.push_back(dma_read_ctrl_data_length);
                for (int i = 0; i < int'(dma_read_ctrl_data_length); i++)
                    beat_q.push_back(src(dma_read_ctrl_data_index + 32'(i)));
            end

            if (rd_pend) void'(beat_q.pop_front());
            if (stray_mode) begin
                dma_read_chnl_valid = 1;
                dma_read_chnl_data  = 32'hDEAD_BEEF;
            end else begin
                if (rd_pend || !dma_read_chnl_valid || beat_q.size() == 0)
                    dma_read_chnl_valid = (beat_q.size() > 0) && !stall();
                if (dma_read_chnl_valid) dma_read_chnl_data = beat_q[0];
            end
            rd_pend = dma_read_chnl_valid && dma_read_chnl_ready && !stray_mode;

            dma_write_ctrl_ready = !stall();
            if (dma_write_ctrl_valid && dma_write_ctrl_ready) begin
                wreq_idx.push_back(dma_write_ctrl_data_index);
                wreq_len.push_back(dma_write_ctrl_data_length);
                wr_cur = dma_write_ctrl_data_index;
            end
            dma_write_chnl_ready = !stall();
            if (dma_write_chnl_valid && dma_write_chnl_ready) begin
                wlog_addr.push_back(wr_cur);
                wlog_data.push_back(dma_write_chnl_data);
                wr_cur++;
            end

            if (acc_done) begin
                check("acc_done_single_cycle", {31'd0, prev_acc}, 0);
                acc_cnt++;
            end
            prev_acc = acc_done;
            p_rc_v = dma_read_ctrl_valid;  p_rc_r = dma_read_ctrl_ready;
            p_rc_i = dma_read_ctrl_data_index; p_rc_l = dma_read_ctrl_data_length;
            p_wc_v = dma_write_ctrl_valid; p_wc_r = dma_write_ctrl_ready;
            p_wc_i = dma_write_ctrl_data_index; p_wc_l = dma_write_ctrl_data_length;
            p_wd_v = dma_write_chnl_valid; p_wd_r = dma_write_chnl_ready;
            p_wd_d = dma_write_chnl_data;
        end
    end

    task automatic start_run(input logic [31:0] rd, input logic [31:0] wr, input logic [31:0] len);
        rreq_idx.delete(); rreq_len.delete(); wreq_idx.delete(); wreq_len.delete();
        wlog_addr.delete(); wlog_data.delete();
        ctrl_seen = 0;
        acc_base  = acc_cnt;
        conf_info_reg1 = rd; conf_info_reg2 = wr; conf_info_reg3 = len;
        conf_done = 1;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (acc_cnt == acc_base && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_completes"}, {31'd0, acc_cnt != acc_base}, 1);
    endtask

    // Reference: split LEN into CHUNK-sized bursts, destination word i = source word i.
    task automatic verify(input string tag, input logic [31:0] rd, input logic [31:0] wr,
                          input int len);
        int          rem, k, bad;
        logic [31:0] c, ri, wi;
        repeat (3) @(negedge clk);
        rem = len; ri = rd; wi = wr; k = 0; bad = 0;
        while (rem > 0) begin
            c = (rem > CW) ? 32'(CW) : 32'(rem);
            if (k >= rreq_idx.size() || rreq_idx[k] !== ri || rreq_len[k] !== c) bad++;
            if (k >= wreq_idx.size() || wreq_idx[k] !== wi || wreq_len[k] !== c) bad++;
            ri += c; wi += c; rem -= int'(c); k++;
        end
        check({tag, "_rd_req_count"}, rreq_idx.size(), k);
        check({tag, "_wr_req_count"}, wreq_idx.size(), k);
        check({tag, "_req_mismatches"}, bad, 0);
        bad = 0;
        for (int i = 0; i < len && i < wlog_data.size(); i++)
            if (wlog_addr[i] !== wr + 32'(i) || wlog_data[i] !== src(rd + 32'(i))) bad++;
        check({tag, "_wr_beats"}, wlog_data.size(), len);
        check({tag, "_data_mismatches"}, bad, 0);
        check({tag, "_acc_done_count"}, acc_cnt - acc_base, 1);
        check({tag, "_chunks_done"}, {16'd0, debug[31:16]}, k);
    endtask

    initial begin : main
        logic [31:0] r_rd, r_wr;
        int          r_len, n;
        rst = 0; conf_done = 0; stall_pct = 0; stray_mode = 0;
        conf_info_reg1 = 0; conf_info_reg2 = 0; conf_info_reg3 = 0;
        seed = $urandom;
        repeat (3) @(negedge clk);
        check("reset_valids_ready_done", {27'd0, dma_read_ctrl_valid, dma_read_chnl_ready,
              dma_write_ctrl_valid, dma_write_chnl_valid, acc_done}, 0);
        check("reset_debug", debug, 0);
        rst = 1;
        @(negedge clk);

        // LEN=40, no stalls, exact burst plan
        start_run(32'h100, 32'h800, 40);
        wait_done("len40");
        conf_done = 0;
        verify("len40", 32'h100, 32'h800, 40);
        check("len40_rd2_index", rreq_idx.size() > 2 ? rreq_idx[2] : 32'hX, 32'h120);
        check("len40_rd2_len", rreq_len.size() > 2 ? rreq_len[2] : 32'hX, 8);
        check("len40_wr1_index", wreq_idx.size() > 1 ? wreq_idx[1] : 32'hX, 32'h810);
        check("const_sizes_user", {16'd0, dma_read_ctrl_data_size, dma_read_ctrl_data_user,
              dma_write_ctrl_data_size, dma_write_ctrl_data_user}, {16'd0, 3'b010, 5'd0, 3'b010, 5'd0});

        // LEN=0: straight to DONE
        start_run(32'h40, 32'h80, 0);
        @(negedge clk);
        check("len0_acc_done_next_cycle", {31'd0, acc_done}, 1);
        @(negedge clk);
        check("len0_acc_done_drops", {31'd0, acc_done}, 0);
        conf_done = 0;
        repeat (3) @(negedge clk);
        check("len0_no_ctrl_valid", {31'd0, ctrl_seen}, 0);
        check("len0_acc_done_count", acc_cnt - acc_base, 1);

        // LEN=100 with random stalls everywhere
        stall_pct = 40;
        start_run(32'h2000, 32'h9000, 100);
        wait_done("len100");
        conf_done = 0;
        verify("len100", 32'h2000, 32'h9000, 100);

        // conf_done held after completion: no re-run until it drops
        stall_pct = 20;
        start_run(32'h300, 32'h400, 20);
        wait_done("held");
        repeat (50) @(negedge clk);
        check("held_one_run", acc_cnt - acc_base, 1);
        check("held_state_wait_clr", {29'd0, debug[2:0]}, 6);
        check("held_no_extra_reads", rreq_idx.size(), 2);
        conf_done = 0;
        @(negedge clk);
        start_run(32'h500, 32'h600, 20);
        wait_done("rerun");
        conf_done = 0;
        verify("rerun", 32'h500, 32'h600, 20);

        // async reset in the middle of chunk 2's read phase
        stall_pct = 0;
        start_run(32'h1000, 32'h5000, 100);
        n = 0;
        while (!(debug[31:16] == 16'd1 && debug[2:0] == 3'd2) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rst_reached_chunk2_rd_data", {31'd0, n < 2000}, 1);
        repeat (3) @(negedge clk);
        #2 rst = 0;
        #1;
        check("rst_async_outputs", {27'd0, dma_read_ctrl_valid, dma_read_chnl_ready,
              dma_write_ctrl_valid, dma_write_chnl_valid, acc_done}, 0);
        check("rst_async_debug", debug, 0);
        conf_done = 0;
        repeat (2) @(negedge clk);
        check("rst_no_acc_done", acc_cnt - acc_base, 0);
        rst = 1;
        @(negedge clk);
        start_run(32'h1000, 32'h7000, 24);
        wait_done("after_rst");
        conf_done = 0;
        verify("after_rst", 32'h1000, 32'h7000, 24);

        // stray read beats while idle, then LEN exactly one chunk
        stray_mode = 1;
        repeat (4) @(negedge clk);
        stray_mode = 0;
        @(negedge clk);
        stall_pct = 30;
        start_run(32'h700, 32'hA00, 16);
        wait_done("len16");
        conf_done = 0;
        verify("len16", 32'h700, 32'hA00, 16);

        // random lengths and bases, including index wrap past 2^32
        for (int t = 0; t < 3; t++) begin
            r_len = int'($urandom_range(1, 60));
            r_rd  = (t == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            r_wr  = (t == 1) ? 32'hFFFF_FFF8 : $urandom;
            stall_pct = int'($urandom_range(0, 50));
            start_run(r_rd, r_wr, 32'(r_len));
            wait_done("random");
            conf_done = 0;
            verify("random", r_rd, r_wr, r_len);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
